// File: rtl/sevenseg_mux_driver.sv
// Multiplexed NUM_DIGITS seven-segment driver with blank gaps, leading-zero blanking and frame-aligned commit.
// Optional macro DECIMAL_POINT_EN adds dp_in/dp_out decimal-point handling.
module sevenseg_mux_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 4,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
`ifdef DECIMAL_POINT_EN
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    dp_out,
`endif
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    pending,
  output logic                    frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [4*NUM_DIGITS-1:0] ALL_BLANK = {NUM_DIGITS{4'hA}};

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d, shadow_q, shadow_d;
  logic                    pending_q, pending_d;
  logic                    tick_q, tick_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [NUM_DIGITS-1:0]   lz_keep;
  logic [NUM_DIGITS-1:0]   sup;
  logic                    lead;
  logic [3:0]              scan_code;
  logic [3:0]              cur_code;
  logic                    wrap;
  logic                    blank;

`ifdef DECIMAL_POINT_EN
  logic [NUM_DIGITS-1:0] dp_disp_q, dp_disp_d, dp_shadow_q, dp_shadow_d;
  logic                  dp_q, dp_d;
  assign lz_keep = dp_disp_q;
`else
  assign lz_keep = '0;
`endif

  function automatic logic [6:0] decode(input logic [3:0] c);
    case (c)
      4'h0:    decode = 7'b0000001;
      4'h1:    decode = 7'b1001111;
      4'h2:    decode = 7'b0010010;
      4'h3:    decode = 7'b0000110;
      4'h4:    decode = 7'b1001100;
      4'h5:    decode = 7'b0100100;
      4'h6:    decode = 7'b0100000;
      4'h7:    decode = 7'b0001111;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0000100;
      4'hF:    decode = 7'b1111110;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // Walk from the most significant digit; suppression stays live only through blank or suppressed zeros.
  always_comb begin
    sup       = '0;
    lead      = 1'b1;
    scan_code = 4'h0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      scan_code = disp_q[4*i +: 4];
      if (LZ_SUPPRESS != 0 && i != 0 && lead && scan_code == 4'h0 && !lz_keep[i])
        sup[i] = 1'b1;
      lead = lead && !lz_keep[i] && (sup[i] || (scan_code >= 4'hA && scan_code <= 4'hE));
    end
  end

  assign cur_code = disp_q[4*int'(idx_q) +: 4];
  assign wrap     = enable && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
  assign blank    = !enable || (int'(cnt_q) < BLANK_CYCLES);

  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    disp_d    = disp_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    tick_d    = 1'b0;
`ifdef DECIMAL_POINT_EN
    dp_disp_d   = dp_disp_q;
    dp_shadow_d = dp_shadow_q;
`endif
    if (!enable) begin
      cnt_d = '0;
      idx_d = '0;
      // Nothing is on screen, so a new value can go straight to the display register.
      if (load) begin
        disp_d    = digits_in;
        pending_d = 1'b0;
`ifdef DECIMAL_POINT_EN
        dp_disp_d = dp_in;
`endif
      end else if (pending_q) begin
        disp_d    = shadow_q;
        pending_d = 1'b0;
`ifdef DECIMAL_POINT_EN
        dp_disp_d = dp_shadow_q;
`endif
      end
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      if (wrap) begin
        tick_d    = 1'b1;
        pending_d = 1'b0;
        if (load) begin
          disp_d = digits_in;
`ifdef DECIMAL_POINT_EN
          dp_disp_d = dp_in;
`endif
        end else if (pending_q) begin
          disp_d = shadow_q;
`ifdef DECIMAL_POINT_EN
          dp_disp_d = dp_shadow_q;
`endif
        end
      end else if (load) begin
        shadow_d  = digits_in;
        pending_d = 1'b1;
`ifdef DECIMAL_POINT_EN
        dp_shadow_d = dp_in;
`endif
      end
    end
    an_d  = blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    seg_d = (blank || sup[idx_q]) ? 7'b1111111 : decode(cur_code);
`ifdef DECIMAL_POINT_EN
    dp_d = !(!blank && dp_disp_q[idx_q]);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      disp_q    <= ALL_BLANK;
      shadow_q  <= ALL_BLANK;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      seg_q     <= 7'b1111111;
      an_q      <= '1;
`ifdef DECIMAL_POINT_EN
      dp_disp_q   <= '0;
      dp_shadow_q <= '0;
      dp_q        <= 1'b1;
`endif
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
`ifdef DECIMAL_POINT_EN
      dp_disp_q   <= dp_disp_d;
      dp_shadow_q <= dp_shadow_d;
      dp_q        <= dp_d;
`endif
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign pending    = pending_q;
  assign frame_tick = tick_q;
`ifdef DECIMAL_POINT_EN
  assign dp_out = dp_q;
`endif

endmodule

// File: doc/sevenseg_mux_driver.md
Name: sevenseg_mux_driver

Overview:
- Parametrised multi-digit successor to the single-digit BCD-to-seven-segment decoder.
- Holds NUM_DIGITS 4-bit codes and time-multiplexes one shared active-low segment bus across NUM_DIGITS active-low digit anodes.
- Refresh is fixed-rate, with an anti-ghosting blank gap at each slot start.
- New values load through a tear-free shadow register committed only at frame boundaries. Sits between calculator result/format logic and board display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..16).
- REFRESH_DIV, 100000, clock cycles per digit slot (>= BLANK_CYCLES+1).
- BLANK_CYCLES, 4, cycles at slot start with all anodes off (0 allowed).
- LZ_SUPPRESS, 1, 1 = blank leading zeros; 0 = show all digits.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  display on; 0 forces blank and holds the scan at its start.
- load  in  1  one-cycle strobe capturing digits_in.
- digits_in  in  4*NUM_DIGITS  codes; digit i = [4i+3:4i], digit 0 rightmost.
- seg_out  out  7  segments {a,b,c,d,e,f,g} = [6:0], active low, registered.
- an_out  out  NUM_DIGITS  anode select, bit i low = digit i lit, registered.
- pending  out  1  shadow holds an uncommitted value.
- frame_tick  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: seg_out=7'b1111111, an_out=all ones, pending=0, frame_tick=0, slot counter=0, digit index=0, display and shadow registers all 4'hA (blank).
- Code map (0 = segment on):
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110, 4:1001100, 5:0100100, 6:0100000, 7:0001111, 8:0000000, 9:0000100.
  - F (minus): 1111110.
  - A-E: blank, 1111111.
- Scan:
  - Slot counter runs 0..REFRESH_DIV-1.
  - At terminal count the counter resets and the index advances, wrapping NUM_DIGITS-1 -> 0.
  - frame_tick is asserted the cycle after the wrap edge.
- Output timing:
  - seg_out and an_out are registered from the current counter, index and display register, so they lag internal state by 1 cycle.
  - While counter < BLANK_CYCLES: an_out = all ones, seg_out = all ones.
  - Otherwise: an_out = ~(1<<index), seg_out = decoded code of digit index.
- Leading-zero suppression (LZ_SUPPRESS=1):
  - Digit i>=1 shows blank if its code is 0 and every higher digit is 0 or blank.
  - Digit 0 is never suppressed.
  - Minus and 1-9 stop suppression.
- Load and commit:
  - load=1 writes digits_in to the shadow register and sets pending. A second load before commit overwrites it (last wins).
  - At the wrap edge, if pending=1, the display register takes the shadow value and pending clears.
  - load coincident with the wrap edge: digits_in is committed directly to the display register at that edge and pending stays 0.
- enable=0:
  - Counter and index are held at 0; outputs are all ones; frame_tick=0.
  - load commits immediately to the display register (no tearing possible); pending stays 0.
- enable 0 -> 1: scan starts at digit 0, counter 0, i.e. a blank gap first.
- rst mid-frame or mid-pending: returns to the reset state on the next edge; the uncommitted shadow value is discarded.

Optional Feature:
- Macro DECIMAL_POINT_EN.
- When defined:
  - Adds input dp_in [NUM_DIGITS-1:0], shadowed and committed exactly like digits_in.
  - Adds output dp_out (1 bit, active low, registered). Low when the current digit's dp bit is 1, outside the blank gap, and enable=1.
  - Reset value of dp_out is 1.
  - A digit with dp set is exempt from leading-zero suppression.
- When not defined: neither port exists; all other behaviour is unchanged.

Test Plan:
- Common setup: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, LZ_SUPPRESS=1.
- Reset, enable=1, no load -> an_out cycles 1111 during gaps and 1110/1101/1011/0111 otherwise; seg_out=1111111 throughout; frame_tick pulses every 32 cycles.
- load digits_in=16'h1234 mid-frame -> pending=1 until wrap. From the next frame: digit3 seg=1001111, digit2 0010010, digit1 0000110, digit0 1001100; pending=0.
- load 16'h0F05 -> digit3 blank, digit2 1111110 (minus), digit1 0000001 (zero not suppressed), digit0 0100100. Then load 16'h0000 -> only digit0 shows 0000001.
- Two loads (16'h1111 then 16'h2222) in one frame -> only 2222 is ever displayed. A load of 16'h3333 on the wrap cycle -> 3333 is shown in the frame that starts at that wrap, with pending=0.
- enable=0 during a scan -> outputs all ones next cycle. load 16'h9876 while disabled is committed immediately. Re-enable -> first 2 cycles blank, then digit0 shows 0100000 (code 6).
- rst asserted with pending=1 mid-slot -> next cycle all outputs at reset values; the following frame shows blank, not the shadow value.
